// File: rtl/mips_pkg.sv
// Shared widths, FSM state type and request payload for the data-memory responder.
package mips_pkg;

    localparam int unsigned DATA_MEM_WIDTH = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_MEM_WIDTH / 8;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                      write;
        logic [DATA_MEM_WIDTH-1:0] addr;
        logic [DATA_MEM_WIDTH-1:0] wdata;
    } dmem_req_t;

    // Little-endian byte lane k of a word.
    function automatic logic [7:0] word_byte(input logic [DATA_MEM_WIDTH-1:0] word,
                                             input logic [CNT_W-1:0] k);
        return 8'(word >> {k, 3'b000});
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide storage: combinational read, synchronous write, asynchronous clear of every byte.
module dmem_byte_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_c = mem[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-level data-memory responder moving one byte per cycle through a byte RAM.
// Optional alignment checking is enabled with the DMEM_MISALIGN_CHECK_EN macro.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [DATA_MEM_WIDTH-1:0] req_addr,
    input  logic [DATA_MEM_WIDTH-1:0] req_wdata,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output logic [DATA_MEM_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [DATA_MEM_WIDTH-1:0] WORD_MASK = ~DATA_MEM_WIDTH'(BYTES_PER_WORD - 1);

    dmem_state_t                  state;
    dmem_state_t                  next_state;
    dmem_req_t                    req_q;
    logic [CNT_W-1:0]             cnt;
    logic [DATA_MEM_WIDTH-9:0]    load_buf;

    logic                         accept_c;
    logic                         misalign_c;
    logic                         last_byte_c;
    logic                         ram_we_c;
    logic [AW-1:0]                ram_addr_c;
    logic [WIDTH-1:0]             ram_wdata_c;
    logic [WIDTH-1:0]             ram_rdata_c;

    assign accept_c    = req_valid && (state == IDLE);
    assign last_byte_c = (state == XFER) && (cnt == CNT_W'(BYTES_PER_WORD - 1));

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_c = (req_addr[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    // Byte address wraps inside the storage by truncation to AW bits.
    assign ram_addr_c  = AW'(req_q.addr + DATA_MEM_WIDTH'(cnt));
    assign ram_we_c    = (state == XFER) && req_q.write;
    assign ram_wdata_c = word_byte(req_q.wdata, cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept_c) next_state = misalign_c ? RESP : XFER;
            XFER:    if (last_byte_c) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latches, byte counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            cnt       <= '0;
            load_buf  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
            if (accept_c) begin
                req_q.write <= req_write;
                req_q.addr  <= req_addr & WORD_MASK;
                req_q.wdata <= req_wdata;
                cnt         <= '0;
                rsp_err     <= misalign_c;
            end
            if (state == XFER) begin
                cnt <= cnt + CNT_W'(1);
                // Loads collect bytes 0..2 here and publish the whole word with byte 3.
                if (!req_q.write) begin
                    load_buf <= {ram_rdata_c, load_buf[DATA_MEM_WIDTH-9:8]};
                    if (last_byte_c) begin
                        rsp_rdata <= {ram_rdata_c, load_buf};
                    end
                end
            end
        end
    end

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we_c),
        .addr    (ram_addr_c),
        .wdata   (ram_wdata_c),
        .rdata_c (ram_rdata_c)
    );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, storage size in bytes; power of two.
REQ-002 Parameter WIDTH, default 8, storage lane width in bits; fixed at 8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  core presents a data-memory request.
REQ-006 req_write  input  1  1 = store, 0 = load; sampled with req_valid.
REQ-007 req_addr  input  DATA_MEM_WIDTH  byte address of the word.
REQ-008 req_wdata  input  DATA_MEM_WIDTH  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle pulse marking completion.
REQ-011 rsp_rdata  output  DATA_MEM_WIDTH  load data; valid with rsp_valid.
REQ-012 rsp_err  output  1  misaligned-request error; valid with rsp_valid.

Function
REQ-013 FSM states IDLE, XFER, RESP; one request in flight at a time.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-015 On accept: latch addr, wdata, write; clear byte counter; go to XFER.
REQ-016 XFER: one byte per cycle for 4 cycles, byte k at addr+k, little-endian (byte 0 = bits 7:0); store writes req_wdata byte k, load fills rsp_rdata byte k.
REQ-017 After byte 3: go to RESP; RESP drives rsp_valid=1 for exactly one cycle, then IDLE.
REQ-018 Latency: accept at cycle N -> rsp_valid at cycle N+5; next accept at earliest N+6.
REQ-019 Byte address SHALL wrap modulo DEPTH (addr+k truncated to log2(DEPTH) bits).
REQ-020 rsp_rdata SHALL hold its last load value until the next load completes; stores leave it unchanged.
REQ-021 req_valid while req_ready=0 SHALL be ignored with no side effect.
REQ-022 Store followed by load to the same address SHALL return the stored word.
REQ-023 rsp_err SHALL be 0 on every response unless REQ-030 applies.

Reset
REQ-024 On rst_n low: FSM to IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, byte counter=0.
REQ-025 All DEPTH storage bytes SHALL clear to 0 on reset.
REQ-026 Reset during XFER SHALL abort the request with no response; storage is cleared per REQ-025.

Configuration
REQ-027 Macro DMEM_MISALIGN_CHECK_EN selects alignment checking.
REQ-028 Without it: req_addr[1:0] SHALL be treated as 00; every request is serviced normally.
REQ-029 With it: a request with req_addr[1:0] != 00 SHALL be checked at accept time.
REQ-030 With it, a misaligned request SHALL skip XFER, go directly to RESP, and pulse rsp_valid=1 with rsp_err=1 one cycle after accept; storage and rsp_rdata are unchanged.

Structure
REQ-031 mips_pkg SHALL hold DATA_MEM_WIDTH and the FSM state enum typedef (dmem_state_t).
REQ-032 Byte storage SHALL be a sub-module dmem_byte_ram: one read/write port, combinational read, synchronous write, async clear.
REQ-033 dmem_responder SHALL hold the FSM, byte counter, address/data latches, and response registers.

Verification
REQ-034 Reset then load addr 0x010 -> rsp_valid at accept+5, rsp_rdata=0x00000000, rsp_err=0.
REQ-035 Store 0xDEADBEEF to 0x020, then load 0x020 -> rsp_rdata=0xDEADBEEF; byte 0x020 reads 0xEF and byte 0x023 reads 0xDE.
REQ-036 Store 0x11223344 to 0xFFC with DEPTH=4096, then load 0xFFC -> 0x11223344; also check a request held on req_valid during busy cycles is accepted only once, in the IDLE cycle.
REQ-037 Assert rst_n low at XFER byte 2 of a store to 0x040 -> no rsp_valid; a later load of 0x040 returns 0x00000000.
REQ-038 With DMEM_MISALIGN_CHECK_EN, store to 0x031 -> rsp_valid and rsp_err=1 at accept+1, memory unchanged. Without the macro, the same store writes the word at 0x030.
